assoc_cache_ctrl: RTL and testbench

ASSOC_CACHE_CTRL -- requirements
Module: assoc_cache_ctrl

---
 rtl/cache_pkg.sv | 39 +++
 rtl/cache_way.sv | 82 ++++++++
 rtl/assoc_cache_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the set-associative cache controller:
//   - cache_state_t : controller FSM states (IDLE, WRITEBACK, ALLOCATE)
//   - DEF_*         : default parameter values used by assoc_cache_ctrl
//   - off_width / idx_width / tag_width : address field widths derived from
//     the geometry (byte address, 4-byte words, BLOCK_WORDS words per line)
// No ports (package).
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_SETS        = 8;
    localparam int DEF_WAYS        = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

    // Word-offset field width inside a line.
    function automatic int off_width(input int block_words);
        return $clog2(block_words);
    endfunction

    // Set-index field width.
    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    // Tag width: whatever is left above byte-in-word, word offset and index.
    function automatic int tag_width(input int addr_w, input int block_words, input int sets);
        return addr_w - 2 - off_width(block_words) - idx_width(sets);
    endfunction

endpackage

// File: rtl/cache_way.sv
// ---------------------------------------------------------------------------
// cache_way
// Storage for one way of the cache: per-set valid, dirty, tag and line data.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset (valid/dirty only)
//   idx                  set index used for lookup and for every write
//   cmp_tag              tag compared against the stored tag for hit
//   hit/valid/dirty/tag  lookup results for set idx
//   line                 full line stored in set idx
//   st_en/st_off/st_data store one word into a resident line, marks it dirty
//   fill_en/fill_tag/fill_line  install a new clean, valid line
// Tag and data arrays are intentionally not reset.
// ---------------------------------------------------------------------------
module cache_way
    import cache_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int SETS        = DEF_SETS,
    parameter int OFF_W       = off_width(DEF_BLOCK_WORDS),
    parameter int IDX_W       = idx_width(DEF_SETS),
    parameter int TAG_W       = tag_width(DEF_ADDR_W, DEF_BLOCK_WORDS, DEF_SETS)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [IDX_W-1:0]              idx,
    input  logic [TAG_W-1:0]              cmp_tag,
    output logic                          hit,
    output logic                          valid,
    output logic                          dirty,
    output logic [TAG_W-1:0]              tag,
    output logic [BLOCK_WORDS*DATA_W-1:0] line,
    input  logic                          st_en,
    input  logic [OFF_W-1:0]              st_off,
    input  logic [DATA_W-1:0]             st_data,
    input  logic                          fill_en,
    input  logic [TAG_W-1:0]              fill_tag,
    input  logic [BLOCK_WORDS*DATA_W-1:0] fill_line
);

    logic [SETS-1:0]               valid_q, valid_d;
    logic [SETS-1:0]               dirty_q, dirty_d;
    logic [TAG_W-1:0]              tag_q  [SETS];
    logic [BLOCK_WORDS*DATA_W-1:0] data_q [SETS];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_en) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end else if (st_en) begin
            dirty_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_line;
        end else if (st_en) begin
            data_q[idx][st_off*DATA_W +: DATA_W] <= st_data;
        end
    end

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag   = tag_q[idx];
    assign line  = data_q[idx];
    assign hit   = valid_q[idx] && (tag_q[idx] == cmp_tag);

endmodule

// File: rtl/assoc_cache_ctrl.sv
// ---------------------------------------------------------------------------
// assoc_cache_ctrl
// Write-back, write-allocate set-associative cache (WAYS = 1 or 2) between a
// CPU word port and a line-wide memory port.
// Ports:
//   clk, rstn           clock (rising edge), asynchronous active-low reset
//   memRd, memWr        CPU load / store request (both set = store)
//   addr, w_data        CPU byte address (bits [1:0] ignored), store data
//   r_data, stall       load data (valid on an IDLE hit), CPU hold request
//   mem_req, mem_we     memory request, write strobe (stable while mem_req)
//   mem_addr            line address {tag, index}
//   mem_wdata/mem_rdata whole-line write / read data
//   mem_ack             one-cycle completion pulse from memory
//   hit_cnt, miss_cnt   only with CACHE_PERF_CNT_EN: wrapping 32-bit counters
// Optional feature macro: CACHE_PERF_CNT_EN
// ---------------------------------------------------------------------------
module assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int SETS        = DEF_SETS,
    parameter int WAYS        = DEF_WAYS
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    memRd,
    input  logic                                    memWr,
    input  logic [ADDR_W-1:0]                       addr,
    input  logic [DATA_W-1:0]                       w_data,
    output logic [DATA_W-1:0]                       r_data,
    output logic                                    stall,
    output logic                                    mem_req,
    output logic                                    mem_we,
    output logic [ADDR_W-off_width(BLOCK_WORDS)-3:0] mem_addr,
    output logic [BLOCK_WORDS*DATA_W-1:0]           mem_wdata,
    input  logic [BLOCK_WORDS*DATA_W-1:0]           mem_rdata,
`ifdef CACHE_PERF_CNT_EN
    output logic [31:0]                             hit_cnt,
    output logic [31:0]                             miss_cnt,
`endif
    input  logic                                    mem_ack
);

    localparam int OFF_W  = off_width(BLOCK_WORDS);
    localparam int IDX_W  = idx_width(SETS);
    localparam int TAG_W  = tag_width(ADDR_W, BLOCK_WORDS, SETS);
    localparam int LINE_W = BLOCK_WORDS * DATA_W;

    logic             req;
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_addr_lsbs;

    assign req              = memRd | memWr;
    assign req_off          = addr[OFF_W+1:2];
    assign req_idx          = addr[OFF_W+2 +: IDX_W];
    assign req_tag          = addr[ADDR_W-1 -: TAG_W];
    assign unused_addr_lsbs = ^addr[1:0];

    cache_state_t     state_q, state_d;
    logic             victim_q, victim_d;
    logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
    // One bit per set naming the way to replace next.
    logic [SETS-1:0]  lru_q, lru_d;

    logic [WAYS-1:0]   way_hit, way_valid, way_dirty;
    logic [WAYS-1:0]   way_st_en, way_fill_en;
    logic [TAG_W-1:0]  way_tag  [WAYS];
    logic [LINE_W-1:0] way_line [WAYS];
    logic [IDX_W-1:0]  way_idx;

    // During a miss the ways are addressed from the latched miss set so the
    // writeback line and fill target cannot move if the CPU misbehaves.
    assign way_idx = (state_q == IDLE) ? req_idx : miss_idx_q;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way #(
            .DATA_W      (DATA_W),
            .BLOCK_WORDS (BLOCK_WORDS),
            .SETS        (SETS),
            .OFF_W       (OFF_W),
            .IDX_W       (IDX_W),
            .TAG_W       (TAG_W)
        ) u_way (
            .clk       (clk),
            .rstn      (rstn),
            .idx       (way_idx),
            .cmp_tag   (req_tag),
            .hit       (way_hit[w]),
            .valid     (way_valid[w]),
            .dirty     (way_dirty[w]),
            .tag       (way_tag[w]),
            .line      (way_line[w]),
            .st_en     (way_st_en[w]),
            .st_off    (req_off),
            .st_data   (w_data),
            .fill_en   (way_fill_en[w]),
            .fill_tag  (miss_tag_q),
            .fill_line (mem_rdata)
        );
    end

    logic hit, hit_way, pick;

    assign hit = |way_hit;

    always_comb begin
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_way = 1'(w);
        end
    end

    // Victim: lowest-numbered invalid way, otherwise the LRU way.
    always_comb begin
        pick = (WAYS == 2) ? lru_q[req_idx] : 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) pick = 1'(w);
        end
    end

    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        miss_idx_d  = miss_idx_q;
        miss_tag_d  = miss_tag_q;
        lru_d       = lru_q;
        way_st_en   = '0;
        way_fill_en = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (memWr) way_st_en[hit_way] = 1'b1;
                        if (WAYS == 2) lru_d[req_idx] = ~hit_way;
                    end else begin
                        victim_d   = pick;
                        miss_idx_d = req_idx;
                        miss_tag_d = req_tag;
                        state_d    = (way_valid[pick] && way_dirty[pick]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {way_tag[victim_q], miss_idx_q};
                mem_wdata = way_line[victim_q];
                if (mem_ack) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag_q, miss_idx_q};
                if (mem_ack) begin
                    way_fill_en[victim_q] = 1'b1;
                    state_d               = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            victim_q   <= 1'b0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            lru_q      <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            lru_q      <= lru_d;
        end
    end

    assign stall = req & ((state_q != IDLE) | ~hit);

    always_comb begin
        r_data = '0;
        if (state_q == IDLE && hit) begin
            r_data = way_line[hit_way][req_off*DATA_W +: DATA_W];
        end
    end

`ifdef CACHE_PERF_CNT_EN
    // replay_q marks the cycle right after a fill, whose hit is the replay of
    // the access already counted as a miss.
    logic        replay_q, replay_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        replay_d   = (state_q == ALLOCATE) && mem_ack;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == IDLE && req) begin
            if (!hit) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end else if (!replay_q) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            replay_q   <= replay_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_assoc_cache_ctrl
// Directed plus randomized bench for assoc_cache_ctrl (default geometry:
// 10-bit address, 32-bit words, 4 words/line, 8 sets, 2 ways). The bench acts
// as the memory and keeps a reference model: a backing store of lines and a
// per-set list of at most two resident lines with recency timestamps.
// Counter checks are included when CACHE_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_assoc_cache_ctrl;

    logic         clk;
    logic         rstn;
    logic         memRd, memWr;
    logic [9:0]   addr;
    logic [31:0]  w_data;
    logic [31:0]  r_data;
    logic         stall;
    logic         mem_req, mem_we;
    logic [5:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    assoc_cache_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .memRd     (memRd),
        .memWr     (memWr),
        .addr      (addr),
        .w_data    (w_data),
        .r_data    (r_data),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
`ifdef CACHE_PERF_CNT_EN
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
`endif
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [127:0] backing [64];
    bit           m_valid [8][2];
    bit           m_dirty [8][2];
    logic [2:0]   m_tag   [8][2];
    logic [127:0] m_line  [8][2];
    int           m_time  [8][2];
    int           now = 0;

    logic [5:0]   last_fill_addr, last_wb_addr;
    logic [127:0] last_wb_data;
    logic [31:0]  last_rdata;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_invalidate();
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 2; i++) begin
                m_valid[s][i] = 1'b0;
                m_dirty[s][i] = 1'b0;
                m_time[s][i]  = 0;
            end
        end
    endtask

    function automatic int find_slot(input int s, input logic [2:0] t);
        for (int i = 0; i < 2; i++) begin
            if (m_valid[s][i] && m_tag[s][i] == t) return i;
        end
        return -1;
    endfunction

    // Any empty slot first, else the least recently used resident line.
    function automatic int pick_slot(input int s);
        for (int i = 0; i < 2; i++) begin
            if (!m_valid[s][i]) return i;
        end
        return (m_time[s][0] < m_time[s][1]) ? 0 : 1;
    endfunction

    // One CPU access, held until the cache stops stalling; the bench serves
    // any memory traffic after dly idle cycles.
    task automatic access(input bit do_wr, input bit do_rd, input logic [9:0] a,
                          input logic [31:0] wd, input int dly);
        int         s, off, slot, v;
        logic [2:0] t;
        logic [5:0] wb_a, fa;
        s     = int'(a[6:4]);
        t     = a[9:7];
        off   = int'(a[3:2]);
        memRd = do_rd;
        memWr = do_wr;
        addr  = a;
        w_data = wd;
        #1;
        slot = find_slot(s, t);
        if (slot < 0) begin
            check("miss_stall", stall, 1);
            check("miss_req_idle", mem_req, 0);
            v = pick_slot(s);
            @(posedge clk);
            @(negedge clk);
            if (m_valid[s][v] && m_dirty[s][v]) begin
                wb_a = {m_tag[s][v], 3'(s)};
                for (int i = 0; i <= dly; i++) begin
                    check("wb_req", mem_req, 1);
                    check("wb_we", mem_we, 1);
                    check("wb_addr", mem_addr, wb_a);
                    check("wb_data", mem_wdata, m_line[s][v]);
                    check("wb_stall", stall, 1);
                    if (i < dly) @(negedge clk);
                end
                last_wb_addr = mem_addr;
                last_wb_data = mem_wdata;
                backing[wb_a] = m_line[s][v];
                mem_ack = 1'b1;
                @(posedge clk);
                @(negedge clk);
                mem_ack = 1'b0;
            end
            fa = {t, 3'(s)};
            for (int i = 0; i <= dly; i++) begin
                check("alloc_req", mem_req, 1);
                check("alloc_we", mem_we, 0);
                check("alloc_addr", mem_addr, fa);
                check("alloc_stall", stall, 1);
                if (i < dly) @(negedge clk);
            end
            last_fill_addr = mem_addr;
            mem_rdata = backing[fa];
            mem_ack   = 1'b1;
            @(posedge clk);
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            m_tag[s][v]   = t;
            m_line[s][v]  = backing[fa];
            slot = v;
            #1;
            check("req_after_ack", mem_req, 0);
        end
        check("hit_stall", stall, 0);
        check("hit_no_req", mem_req, 0);
        if (!do_wr) check("r_data", r_data, {96'd0, m_line[s][slot][off*32 +: 32]});
        last_rdata = r_data;
        @(posedge clk);
        now++;
        m_time[s][slot] = now;
        if (do_wr) begin
            m_line[s][slot][off*32 +: 32] = wd;
            m_dirty[s][slot] = 1'b1;
        end
        @(negedge clk);
        memRd = 1'b0;
        memWr = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn      = 1'b0;
        memRd     = 1'b0;
        memWr     = 1'b0;
        addr      = '0;
        w_data    = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 64; i++) backing[i] = {$urandom, $urandom, $urandom, $urandom};
        backing[4][31:0] = 32'h11111111;
        model_invalidate();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_r_data", r_data, 0);
        memRd = 1'b1;
        addr  = 10'h040;
        #1;
        check("rst_stall_req", stall, 1);
        check("rst_req_low", mem_req, 0);
        @(negedge clk);
        memRd = 1'b0;
        rstn  = 1'b1;
        @(negedge clk);
`ifdef CACHE_PERF_CNT_EN
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
`endif

        // Cold read miss, write hit, read hit
        access(1'b0, 1'b1, 10'h040, 32'h0, 0);
        check("cold_fill_addr", last_fill_addr, 6'h04);
        check("cold_rdata", last_rdata, 32'h11111111);
        access(1'b1, 1'b0, 10'h040, 32'hDEADBEEF, 0);
        access(1'b0, 1'b1, 10'h040, 32'h0, 0);
        check("wr_then_rd", last_rdata, 32'hDEADBEEF);

        // Fill the other way, then force eviction of the dirty line with slow acks
        access(1'b0, 1'b1, 10'h0C0, 32'h0, 1);
        access(1'b0, 1'b1, 10'h140, 32'h0, 5);
        check("evict_wb_addr", last_wb_addr, 6'h04);
        check("evict_wb_word0", last_wb_data[31:0], 32'hDEADBEEF);
        check("evict_fill_addr", last_fill_addr, 6'h14);
`ifdef CACHE_PERF_CNT_EN
        check("perf_miss_cnt", miss_cnt, 3);
        check("perf_hit_cnt", hit_cnt, 2);
`endif

        // No request: nothing moves
        for (int i = 0; i < 3; i++) begin
            check("idle_stall", stall, 0);
            check("idle_req", mem_req, 0);
            @(negedge clk);
        end

        // Reset in the middle of a fill
        memRd = 1'b1;
        addr  = 10'h040;
        #1;
        check("abort_miss_stall", stall, 1);
        @(negedge clk);
        check("abort_alloc_req", mem_req, 1);
        check("abort_alloc_we", mem_we, 0);
        check("abort_alloc_addr", mem_addr, 6'h04);
        #2;
        rstn = 1'b0;
        #1;
        check("abort_req_drop", mem_req, 0);
        check("abort_addr_zero", mem_addr, 0);
        check("abort_stall", stall, 1);
        @(negedge clk);
        memRd = 1'b0;
        rstn  = 1'b1;
        model_invalidate();
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("stray_ack_req", mem_req, 0);
        check("stray_ack_stall", stall, 0);
        @(negedge clk);
        access(1'b0, 1'b1, 10'h040, 32'h0, 2);
        check("post_abort_fill_addr", last_fill_addr, 6'h04);
        check("post_abort_rdata", last_rdata, 32'hDEADBEEF);

        // Randomized traffic over a few sets with conflicting tags
        for (int n = 0; n < 200; n++) begin
            logic [9:0] a;
            int         op;
            a  = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
            op = $urandom_range(0, 3);
            case (op)
                0, 1:    access(1'b0, 1'b1, a, 32'h0, $urandom_range(0, 3));
                2:       access(1'b1, 1'b0, a, $urandom, $urandom_range(0, 3));
                default: access(1'b1, 1'b1, a, $urandom, $urandom_range(0, 3));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
